brd_wb2ps_wc_lookup: RTL and testbench

Cache lookup and hit/miss controller for the 4-way, 16-line, 64-byte/line Wishbone↔PSRAM write-back cache. It sits directly upstream of the tag/data RAM control block and runs in the cpuclk domain.
- Accepts one CPU request at a time and reads the tags.
- Compares the 4 ways and updates the LRU.
- Performs the hit read or hit write on the data RAM.
- On a miss, selects the victim and hands it to the refill/write-back engine, then retries the lookup.

---
 rtl/brd_wb2ps_wc_lookup.sv | 268 ++++++++++++++++++++++++++
 tb/tb_brd_wb2ps_wc_lookup.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/brd_wb2ps_wc_lookup.sv
// ---------------------------------------------------------------------------
// brd_wb2ps_wc_lookup
//   Lookup / hit-miss controller for the 4-way, 16-line, 64 B/line write-back
//   cache in front of PSRAM. It takes one CPU request at a time and reads the
//   tags. It compares the ways, ages the LRU, and performs the hit access on
//   the data RAM. On a miss it hands a victim to the refill engine and then
//   retries the lookup.
//
// Ports
//   cpuclk / WSHRST          clock, async active-low reset
//   taginit_busy             blocks acceptance while tag init runs
//   req_*                    CPU request (word address [22:2])
//   busy / ack / rdata       request status and read return
//   READ_TAG, read_lineno    tag RAM read (data valid next cycle)
//   READ_DATA_BUS, read_adr_lsb  data RAM read (data valid next cycle)
//   tag_*N, rf_cache_rdataN  tag / data RAM outputs for way N
//   rewrite_lru, w_lruN      LRU write-back
//   rewrite_tag, w_tagadr, w_valid, w_dirty, w_dc  tag / data write strobes
//   r_w_adrs/wdata/strb      latched request for the data path
//   miss_*                   handshake and victim info for the refill engine
// ---------------------------------------------------------------------------

// Per-way tag compare and victim candidate.
module brd_wb2ps_wc_way (
  input  logic        vld,
  input  logic [12:0] addr,
  input  logic [1:0]  lru,
  input  logic [12:0] ref_tag,
  output logic        hit,
  output logic        oldest
);
  assign hit    = vld & (addr == ref_tag);
  assign oldest = (lru == 2'b11);
endmodule

module brd_wb2ps_wc_lookup (
  input  logic        cpuclk,
  input  logic        WSHRST,
  input  logic        taginit_busy,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [20:0] req_adr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_strb,
  output logic        busy,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        READ_TAG,
  output logic [3:0]  read_lineno,
  output logic        READ_DATA_BUS,
  output logic [3:0]  read_adr_lsb,
  input  logic [12:0] tag_addr0, tag_addr1, tag_addr2, tag_addr3,
  input  logic [1:0]  tag_lru0, tag_lru1, tag_lru2, tag_lru3,
  input  logic        tag_valid0, tag_valid1, tag_valid2, tag_valid3,
  input  logic        tag_dirty0, tag_dirty1, tag_dirty2, tag_dirty3,
  input  logic [31:0] rf_cache_rdata0, rf_cache_rdata1,
  input  logic [31:0] rf_cache_rdata2, rf_cache_rdata3,
  output logic        rewrite_lru,
  output logic [1:0]  w_lru0, w_lru1, w_lru2, w_lru3,
  output logic [3:0]  rewrite_tag,
  output logic [12:0] w_tagadr,
  output logic        w_valid,
  output logic        w_dirty,
  output logic [3:0]  w_dc,
  output logic [20:0] r_w_adrs,
  output logic [31:0] r_w_wdata,
  output logic [3:0]  r_w_strb,
  output logic        miss_req,
  output logic [3:0]  miss_wayno,
  output logic [3:0]  miss_lineno,
  output logic [12:0] miss_fill_tagadr,
  output logic        miss_wb_need,
  output logic [12:0] miss_wb_tagadr,
  input  logic        miss_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_TAGRD, S_JUDGE, S_RDATA, S_ACK, S_MISS, S_TAGUPD
  } state_t;

  state_t state_q, state_d;

  logic [20:0] r_w_adrs_q,  r_w_adrs_d;
  logic [31:0] r_w_wdata_q, r_w_wdata_d;
  logic [3:0]  r_w_strb_q,  r_w_strb_d;
  logic        r_w_we_q,    r_w_we_d;
  logic [31:0] rdata_q,     rdata_d;
  logic [1:0]  hit_way_q,   hit_way_d;
  logic [3:0]  miss_wayno_q,       miss_wayno_d;
  logic [3:0]  miss_lineno_q,      miss_lineno_d;
  logic [12:0] miss_fill_tagadr_q, miss_fill_tagadr_d;
  logic        miss_wb_need_q,     miss_wb_need_d;
  logic [12:0] miss_wb_tagadr_q,   miss_wb_tagadr_d;

  logic [3:0][12:0] t_addr;
  logic [3:0][1:0]  t_lru;
  logic [3:0]       t_vld, t_dty;
  logic [3:0][31:0] c_rdata;
  logic [3:0]       hit, oldest;
  logic [3:0][1:0]  w_lru;
  logic [1:0]       hit_idx, vic_idx;
  logic             hit_any;
  logic [12:0]      req_tag;

  assign t_addr  = {tag_addr3, tag_addr2, tag_addr1, tag_addr0};
  assign t_lru   = {tag_lru3, tag_lru2, tag_lru1, tag_lru0};
  assign t_vld   = {tag_valid3, tag_valid2, tag_valid1, tag_valid0};
  assign t_dty   = {tag_dirty3, tag_dirty2, tag_dirty1, tag_dirty0};
  assign c_rdata = {rf_cache_rdata3, rf_cache_rdata2, rf_cache_rdata1, rf_cache_rdata0};
  assign req_tag = r_w_adrs_q[20:8];

  for (genvar g = 0; g < 4; g++) begin : g_way
    brd_wb2ps_wc_way u_way (
      .vld    (t_vld[g]),
      .addr   (t_addr[g]),
      .lru    (t_lru[g]),
      .ref_tag(req_tag),
      .hit    (hit[g]),
      .oldest (oldest[g])
    );
  end

  // Lowest index wins for both the hit way and the victim; way3 is the
  // victim fallback when no way reports LRU=3.
  always_comb begin
    hit_idx = 2'd0;
    vic_idx = 2'd3;
    for (int i = 3; i >= 0; i--) begin
      if (hit[i])    hit_idx = 2'(i);
      if (oldest[i]) vic_idx = 2'(i);
    end
  end
  assign hit_any = |hit;

  always_comb begin
    state_d            = state_q;
    r_w_adrs_d         = r_w_adrs_q;
    r_w_wdata_d        = r_w_wdata_q;
    r_w_strb_d         = r_w_strb_q;
    r_w_we_d           = r_w_we_q;
    rdata_d            = rdata_q;
    hit_way_d          = hit_way_q;
    miss_wayno_d       = miss_wayno_q;
    miss_lineno_d      = miss_lineno_q;
    miss_fill_tagadr_d = miss_fill_tagadr_q;
    miss_wb_need_d     = miss_wb_need_q;
    miss_wb_tagadr_d   = miss_wb_tagadr_q;
    READ_TAG      = 1'b0;
    READ_DATA_BUS = 1'b0;
    rewrite_lru   = 1'b0;
    w_lru         = '0;
    rewrite_tag   = 4'b0;
    w_tagadr      = 13'd0;
    w_valid       = 1'b0;
    w_dirty       = 1'b0;
    w_dc          = 4'b0;
    ack           = 1'b0;
    miss_req      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid && !taginit_busy) begin
          r_w_adrs_d  = req_adr;
          r_w_wdata_d = req_wdata;
          r_w_strb_d  = req_strb;
          r_w_we_d    = req_we;
          state_d     = S_TAGRD;
        end
      end
      S_TAGRD: begin
        READ_TAG = 1'b1;
        state_d  = S_JUDGE;
      end
      S_JUDGE: begin
        if (hit_any) begin
          // Hit way becomes MRU; ways younger than it age by one.
          rewrite_lru = 1'b1;
          for (int i = 0; i < 4; i++)
            w_lru[i] = (t_lru[i] < t_lru[hit_idx]) ? t_lru[i] + 2'd1 : t_lru[i];
          w_lru[hit_idx] = 2'd0;
          hit_way_d = hit_idx;
          if (r_w_we_q) begin
            w_dc        = 4'b0001 << hit_idx;
            rewrite_tag = 4'b0001 << hit_idx;
            w_tagadr    = req_tag;
            w_valid     = 1'b1;
            w_dirty     = 1'b1;
            state_d     = S_ACK;
          end else begin
            READ_DATA_BUS = 1'b1;
            state_d       = S_RDATA;
          end
        end else begin
          miss_wayno_d       = 4'b0001 << vic_idx;
          miss_lineno_d      = r_w_adrs_q[7:4];
          miss_fill_tagadr_d = req_tag;
          miss_wb_need_d     = t_vld[vic_idx] & t_dty[vic_idx];
          miss_wb_tagadr_d   = t_addr[vic_idx];
          state_d            = S_MISS;
        end
      end
      S_RDATA: begin
        rdata_d = c_rdata[hit_way_q];
        state_d = S_ACK;
      end
      S_ACK: begin
        ack     = 1'b1;
        state_d = S_IDLE;
      end
      S_MISS: begin
        miss_req = 1'b1;
        if (miss_done) state_d = S_TAGUPD;
      end
      S_TAGUPD: begin
        // Install the refilled line clean, then re-run the lookup.
        rewrite_tag = miss_wayno_q;
        w_tagadr    = miss_fill_tagadr_q;
        w_valid     = 1'b1;
        state_d     = S_TAGRD;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge cpuclk or negedge WSHRST) begin
    if (!WSHRST) begin
      state_q            <= S_IDLE;
      r_w_adrs_q         <= '0;
      r_w_wdata_q        <= '0;
      r_w_strb_q         <= '0;
      r_w_we_q           <= 1'b0;
      rdata_q            <= '0;
      hit_way_q          <= '0;
      miss_wayno_q       <= '0;
      miss_lineno_q      <= '0;
      miss_fill_tagadr_q <= '0;
      miss_wb_need_q     <= 1'b0;
      miss_wb_tagadr_q   <= '0;
    end else begin
      state_q            <= state_d;
      r_w_adrs_q         <= r_w_adrs_d;
      r_w_wdata_q        <= r_w_wdata_d;
      r_w_strb_q         <= r_w_strb_d;
      r_w_we_q           <= r_w_we_d;
      rdata_q            <= rdata_d;
      hit_way_q          <= hit_way_d;
      miss_wayno_q       <= miss_wayno_d;
      miss_lineno_q      <= miss_lineno_d;
      miss_fill_tagadr_q <= miss_fill_tagadr_d;
      miss_wb_need_q     <= miss_wb_need_d;
      miss_wb_tagadr_q   <= miss_wb_tagadr_d;
    end
  end

  assign busy             = (state_q != S_IDLE);
  assign rdata            = rdata_q;
  assign read_lineno      = r_w_adrs_q[7:4];
  assign read_adr_lsb     = r_w_adrs_q[3:0];
  assign r_w_adrs         = r_w_adrs_q;
  assign r_w_wdata        = r_w_wdata_q;
  assign r_w_strb         = r_w_strb_q;
  assign miss_wayno       = miss_wayno_q;
  assign miss_lineno      = miss_lineno_q;
  assign miss_fill_tagadr = miss_fill_tagadr_q;
  assign miss_wb_need     = miss_wb_need_q;
  assign miss_wb_tagadr   = miss_wb_tagadr_q;
  assign {w_lru3, w_lru2, w_lru1, w_lru0} = w_lru;

endmodule

// File: tb/tb_brd_wb2ps_wc_lookup.sv
module tb_brd_wb2ps_wc_lookup;

  logic        cpuclk = 1'b0;
  logic        WSHRST = 1'b0;
  logic        taginit_busy = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0;
  logic [20:0] req_adr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_strb = '0;
  logic        miss_done = 1'b0;

  logic [12:0] ta [4];
  logic [1:0]  tl [4];
  logic        tv [4], td [4];
  logic [31:0] rf [4];

  logic        busy, ack, READ_TAG, READ_DATA_BUS, rewrite_lru, w_valid, w_dirty;
  logic        miss_req, miss_wb_need;
  logic [31:0] rdata, r_w_wdata;
  logic [3:0]  read_lineno, read_adr_lsb, rewrite_tag, w_dc, r_w_strb;
  logic [3:0]  miss_wayno, miss_lineno;
  logic [1:0]  w_lru0, w_lru1, w_lru2, w_lru3;
  logic [12:0] w_tagadr, miss_fill_tagadr, miss_wb_tagadr;
  logic [20:0] r_w_adrs;

  int checks = 0;
  int errors = 0;

  always #5 cpuclk = ~cpuclk;

  brd_wb2ps_wc_lookup dut (
    .cpuclk(cpuclk), .WSHRST(WSHRST), .taginit_busy(taginit_busy),
    .req_valid(req_valid), .req_we(req_we), .req_adr(req_adr),
    .req_wdata(req_wdata), .req_strb(req_strb),
    .busy(busy), .ack(ack), .rdata(rdata),
    .READ_TAG(READ_TAG), .read_lineno(read_lineno),
    .READ_DATA_BUS(READ_DATA_BUS), .read_adr_lsb(read_adr_lsb),
    .tag_addr0(ta[0]), .tag_addr1(ta[1]), .tag_addr2(ta[2]), .tag_addr3(ta[3]),
    .tag_lru0(tl[0]), .tag_lru1(tl[1]), .tag_lru2(tl[2]), .tag_lru3(tl[3]),
    .tag_valid0(tv[0]), .tag_valid1(tv[1]), .tag_valid2(tv[2]), .tag_valid3(tv[3]),
    .tag_dirty0(td[0]), .tag_dirty1(td[1]), .tag_dirty2(td[2]), .tag_dirty3(td[3]),
    .rf_cache_rdata0(rf[0]), .rf_cache_rdata1(rf[1]),
    .rf_cache_rdata2(rf[2]), .rf_cache_rdata3(rf[3]),
    .rewrite_lru(rewrite_lru),
    .w_lru0(w_lru0), .w_lru1(w_lru1), .w_lru2(w_lru2), .w_lru3(w_lru3),
    .rewrite_tag(rewrite_tag), .w_tagadr(w_tagadr), .w_valid(w_valid),
    .w_dirty(w_dirty), .w_dc(w_dc),
    .r_w_adrs(r_w_adrs), .r_w_wdata(r_w_wdata), .r_w_strb(r_w_strb),
    .miss_req(miss_req), .miss_wayno(miss_wayno), .miss_lineno(miss_lineno),
    .miss_fill_tagadr(miss_fill_tagadr), .miss_wb_need(miss_wb_need),
    .miss_wb_tagadr(miss_wb_tagadr), .miss_done(miss_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge cpuclk);
    #1;
  endtask

  task automatic set_tags(input logic [12:0] a0, a1, a2, a3,
                          input logic [1:0] l0, l1, l2, l3,
                          input logic [3:0] v, d);
    ta[0] = a0; ta[1] = a1; ta[2] = a2; ta[3] = a3;
    tl[0] = l0; tl[1] = l1; tl[2] = l2; tl[3] = l3;
    for (int i = 0; i < 4; i++) begin
      tv[i] = v[i];
      td[i] = d[i];
    end
  endtask

  // Returns after the acceptance edge; the block is then in TAGRD.
  task automatic issue(input logic we, input logic [20:0] adr,
                       input logic [31:0] wd, input logic [3:0] sb);
    req_valid = 1'b1; req_we = we; req_adr = adr; req_wdata = wd; req_strb = sb;
    step();
    req_valid = 1'b0;
  endtask

  task automatic wait_ack(input string tag);
    int n = 0;
    while (!ack && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_ack_seen"}, {31'd0, ack}, 32'd1);
  endtask

  function automatic logic [31:0] lru_pk();
    return {24'd0, w_lru3, w_lru2, w_lru1, w_lru0};
  endfunction

  initial begin
    for (int i = 0; i < 4; i++) rf[i] = 32'hC0DE_0000 + 32'(i);
    set_tags(13'd0, 13'd0, 13'd0, 13'd0, 2'd3, 2'd2, 2'd1, 2'd0, 4'b0000, 4'b0000);

    // Reset state
    step(); step();
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_ack", {31'd0, ack}, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_readtag", {31'd0, READ_TAG}, 0);
    chk("rst_wlru", lru_pk(), 0);
    chk("rst_miss", {miss_req, miss_wb_need, miss_wayno, miss_lineno}, 0);
    chk("rst_missfill", {19'd0, miss_fill_tagadr}, 0);
    chk("rst_rwadrs", {11'd0, r_w_adrs}, 0);
    #2 WSHRST = 1'b1;
    step();

    // Cold read miss on line 1 (byte 0x40)
    issue(1'b0, 21'h000010, 32'd0, 4'hF);
    chk("cold_readtag", {31'd0, READ_TAG}, 1);
    chk("cold_busy", {31'd0, busy}, 1);
    chk("cold_lineno", {28'd0, read_lineno}, 1);
    step(); // JUDGE
    chk("cold_judge_nolru", {30'd0, rewrite_lru, READ_DATA_BUS}, 0);
    step(); // MISS
    chk("cold_missreq", {31'd0, miss_req}, 1);
    chk("cold_wayno", {28'd0, miss_wayno}, 32'h1);
    chk("cold_wbneed", {31'd0, miss_wb_need}, 0);
    chk("cold_fill", {19'd0, miss_fill_tagadr}, 0);
    chk("cold_mline", {28'd0, miss_lineno}, 1);
    step();
    miss_done = 1'b1;
    step(); // TAGUPD
    miss_done = 1'b0;
    chk("cold_upd_tag", {28'd0, rewrite_tag}, 32'h1);
    chk("cold_upd_vd", {30'd0, w_valid, w_dirty}, 32'h2);
    chk("cold_upd_noreq", {31'd0, miss_req}, 0);
    tv[0] = 1'b1; ta[0] = 13'd0;
    step(); // TAGRD
    chk("cold_retry_rt", {31'd0, READ_TAG}, 1);
    step(); // JUDGE: hit way0, LRU {0,3,2,1}
    chk("cold_retry_lru", lru_pk(), {24'd0, 2'd1, 2'd2, 2'd3, 2'd0});
    chk("cold_retry_rdb", {30'd0, rewrite_lru, READ_DATA_BUS}, 32'h3);
    step(); step(); // RDATA, ACK
    chk("cold_ack", {31'd0, ack}, 1);
    chk("cold_rdata", rdata, rf[0]);
    step();
    chk("cold_idle", {30'd0, busy, ack}, 0);

    // Write hit way0, LRU {0,3,2,1} stays unchanged
    set_tags(13'd0, 13'd0, 13'd0, 13'd0, 2'd0, 2'd3, 2'd2, 2'd1, 4'b0001, 4'b0000);
    issue(1'b1, 21'h000010, 32'hA5A5A5A5, 4'b0011);
    chk("wr_strb", {28'd0, r_w_strb}, 32'h3);
    chk("wr_wdata", r_w_wdata, 32'hA5A5A5A5);
    step(); // JUDGE
    chk("wr_dc", {28'd0, w_dc}, 32'h1);
    chk("wr_rtag", {28'd0, rewrite_tag}, 32'h1);
    chk("wr_vd", {30'd0, w_valid, w_dirty}, 32'h3);
    chk("wr_lru", lru_pk(), {24'd0, 2'd1, 2'd2, 2'd3, 2'd0});
    step(); // cycle 3
    chk("wr_ack_c3", {31'd0, ack}, 1);
    chk("wr_dc_off", {28'd0, w_dc}, 0);
    step();

    // LRU middle hit: way2 with LRU {0,1,2,3}
    set_tags(13'd0, 13'd1, 13'd2, 13'd3, 2'd0, 2'd1, 2'd2, 2'd3, 4'b1111, 4'b0000);
    issue(1'b0, 21'h000215, 32'd0, 4'hF);
    chk("mid_wordlsb", {28'd0, read_adr_lsb}, 32'h5);
    step();
    chk("mid_lru", lru_pk(), {24'd0, 2'd3, 2'd0, 2'd2, 2'd1});
    step(); step();
    chk("mid_ack_c4", {31'd0, ack}, 1);
    chk("mid_rdata", rdata, rf[2]);
    step();

    // Multiple ways hit: lowest index (way1) wins
    set_tags(13'd0, 13'd5, 13'd5, 13'd3, 2'd0, 2'd1, 2'd2, 2'd3, 4'b1111, 4'b0000);
    issue(1'b0, 21'h000510, 32'd0, 4'hF);
    step(); step();
    wait_ack("multi");
    chk("multi_rdata", rdata, rf[1]);
    step();

    // taginit_busy blocks acceptance
    taginit_busy = 1'b1;
    req_valid = 1'b1; req_we = 1'b0; req_adr = 21'h000010;
    begin
      int seen = 0;
      repeat (4) begin
        step();
        if (READ_TAG || busy) seen++;
      end
      chk("tinit_blocked", 32'(seen), 0);
    end
    req_valid = 1'b0;
    taginit_busy = 1'b0;
    step();

    // Stray miss_done while idle is ignored
    miss_done = 1'b1;
    step();
    miss_done = 1'b0;
    chk("stray_done", {30'd0, busy, miss_req}, 0);

    // Dirty eviction: all ways valid+dirty, tags 0..3, way0 oldest
    set_tags(13'd0, 13'd1, 13'd2, 13'd3, 2'd3, 2'd2, 2'd1, 2'd0, 4'b1111, 4'b1111);
    issue(1'b0, 21'h000410, 32'd0, 4'hF);
    step(); step(); // MISS
    chk("evict_wayno", {28'd0, miss_wayno}, 32'h1);
    chk("evict_wbneed", {31'd0, miss_wb_need}, 1);
    chk("evict_wbtag", {19'd0, miss_wb_tagadr}, 0);
    chk("evict_fill", {19'd0, miss_fill_tagadr}, 4);
    begin
      int hi = 0;
      repeat (20) begin
        if (miss_req) hi++;
        step();
      end
      chk("stall_missreq_cycles", 32'(hi), 20);
    end
    miss_done = 1'b1;
    chk("stall_still_req", {31'd0, miss_req}, 1);
    step();
    miss_done = 1'b0;
    chk("stall_upd_tag", {28'd0, rewrite_tag}, 32'h1);
    chk("stall_upd_tagadr", {19'd0, w_tagadr}, 4);
    chk("stall_req_drop", {31'd0, miss_req}, 0);
    ta[0] = 13'd4; td[0] = 1'b0;
    wait_ack("evict");
    chk("evict_rdata", rdata, rf[0]);
    step();

    // No LRU=3 way: victim falls back to way3; reset during MISS
    set_tags(13'd4, 13'd1, 13'd2, 13'd3, 2'd0, 2'd1, 2'd2, 2'd2, 4'b1111, 4'b1111);
    issue(1'b0, 21'h000710, 32'd0, 4'hF);
    step(); step();
    chk("fb_wayno", {28'd0, miss_wayno}, 32'h8);
    chk("fb_wbtag", {19'd0, miss_wb_tagadr}, 3);
    #2 WSHRST = 1'b0;
    #1;
    chk("arst_missreq", {31'd0, miss_req}, 0);
    chk("arst_busy", {31'd0, busy}, 0);
    chk("arst_wayno", {28'd0, miss_wayno}, 0);
    step();
    #2 WSHRST = 1'b1;
    step();
    issue(1'b1, 21'h000410, 32'h12345678, 4'hF);
    step();
    chk("post_rst_dc", {28'd0, w_dc}, 32'h1);
    step();
    chk("post_rst_ack", {31'd0, ack}, 1);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
